// File: rtl/tlight_monitor.sv
// tlight_monitor: passive checker that rebuilds the tlight phase from the ns/we lamp pairs and flags bad patterns.
// Define TLIGHT_MON_TIMING_EN to build the phase dwell checker that drives err_timing.
module tlight_monitor #(
  parameter int unsigned READY_CYCLES = 3,
  parameter int unsigned GO_CYCLES    = 15,
  parameter int unsigned STOP_CYCLES  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  ns,
  input  logic [2:0]  we,
  output logic [2:0]  phase,
  output logic        phase_valid,
  output logic        err_illegal,
  output logic        err_conflict,
  output logic        err_seq,
  output logic        err_timing,
  output logic [15:0] cycles_done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WE_READY = 3'd1,
    S_WE_GO    = 3'd2,
    S_WE_STOP  = 3'd3,
    S_NS_READY = 3'd4,
    S_NS_GO    = 3'd5,
    S_NS_STOP  = 3'd6,
    S_LOST     = 3'd7
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_t state_q, state_d;
  logic   lamp_illegal, lamp_conflict;
  logic   pair_rr, pair_ry, pair_rg, pair_yr, pair_gr;
  logic   valid_d, seq_set, rotate;

  function automatic logic is_phase(state_t s);
    return (s != S_IDLE) && (s != S_LOST);
  endfunction

  // Lamp decode; conflict is only acted on when both buses are legal codes
  always_comb begin
    lamp_illegal  = !(ns inside {RED, YEL, GRN}) || !(we inside {RED, YEL, GRN});
    lamp_conflict = (ns != RED) && (we != RED);
    pair_rr = (ns == RED) && (we == RED);
    pair_ry = (ns == RED) && (we == YEL);
    pair_rg = (ns == RED) && (we == GRN);
    pair_yr = (ns == YEL) && (we == RED);
    pair_gr = (ns == GRN) && (we == RED);
  end

  // Next phase: RY/YR are disambiguated by the current phase
  always_comb begin
    state_d = state_q;
    if (lamp_illegal || lamp_conflict) begin
      state_d = S_LOST;
    end else begin
      case (state_q)
        S_IDLE:     if (pair_ry) state_d = S_WE_READY; else if (!pair_rr) state_d = S_LOST;
        S_WE_READY: if (pair_rg) state_d = S_WE_GO;    else if (!pair_ry) state_d = S_LOST;
        S_WE_GO:    if (pair_ry) state_d = S_WE_STOP;  else if (!pair_rg) state_d = S_LOST;
        S_WE_STOP:  if (pair_yr) state_d = S_NS_READY; else if (!pair_ry) state_d = S_LOST;
        S_NS_READY: if (pair_gr) state_d = S_NS_GO;    else if (!pair_yr) state_d = S_LOST;
        S_NS_GO:    if (pair_yr) state_d = S_NS_STOP;  else if (!pair_gr) state_d = S_LOST;
        S_NS_STOP:  if (pair_ry) state_d = S_WE_READY; else if (!pair_yr) state_d = S_LOST;
        S_LOST: begin
          if (pair_rg)      state_d = S_WE_GO;
          else if (pair_gr) state_d = S_NS_GO;
          else if (pair_rr) state_d = S_IDLE;
        end
        default: state_d = S_LOST;
      endcase
    end
  end

  // Output strobes derived from the transition about to be taken
  always_comb begin
    valid_d = is_phase(state_d);
    seq_set = is_phase(state_q) && (state_d == S_LOST) && !lamp_illegal && !lamp_conflict;
    rotate  = (state_q == S_NS_STOP) && (state_d == S_WE_READY);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_valid  <= 1'b0;
      err_illegal  <= 1'b0;
      err_conflict <= 1'b0;
      err_seq      <= 1'b0;
      cycles_done  <= 16'd0;
    end else begin
      state_q     <= state_d;
      phase_valid <= valid_d;
      if (lamp_illegal) err_illegal <= 1'b1;
      if (lamp_conflict && !lamp_illegal) err_conflict <= 1'b1;
      if (seq_set) err_seq <= 1'b1;
      if (rotate && (cycles_done != 16'hFFFF)) cycles_done <= cycles_done + 16'd1;
    end
  end

  assign phase = state_q;

`ifdef TLIGHT_MON_TIMING_EN
  logic [7:0] dwell_q;
  logic       check_q;
  logic [7:0] dwell_req;
  logic       timing_set;

  // Dwell compare on leaving a phase that was entered from another phase
  always_comb begin
    dwell_req = 8'd0;
    case (state_q)
      S_WE_READY, S_NS_READY: dwell_req = 8'(READY_CYCLES);
      S_WE_GO, S_NS_GO:       dwell_req = 8'(GO_CYCLES);
      S_WE_STOP, S_NS_STOP:   dwell_req = 8'(STOP_CYCLES);
      default:                dwell_req = 8'd0;
    endcase
    timing_set = (state_d != state_q) && check_q && is_phase(state_q) && (dwell_q != dwell_req);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dwell_q    <= 8'd0;
      check_q    <= 1'b0;
      err_timing <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        dwell_q <= 8'd1;
        check_q <= is_phase(state_q);
      end else if (dwell_q != 8'hFF) begin
        dwell_q <= dwell_q + 8'd1;
      end
      if (timing_set) err_timing <= 1'b1;
    end
  end
`else
  assign err_timing = 1'b0;
`endif

endmodule

// File: tb/tb_tlight_monitor.sv
// Self-checking bench for tlight_monitor: directed scenarios plus randomized lamp traffic against a table-driven model.
// Follows the TLIGHT_MON_TIMING_EN define to know whether err_timing is expected to fire.
module tb_tlight_monitor;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [5:0] P_RR = {RED, RED};
  localparam logic [5:0] P_RY = {RED, YEL};
  localparam logic [5:0] P_RG = {RED, GRN};
  localparam logic [5:0] P_YR = {YEL, RED};
  localparam logic [5:0] P_GR = {GRN, RED};
  localparam logic [5:0] P_GG = {GRN, GRN};

`ifdef TLIGHT_MON_TIMING_EN
  localparam bit TIMING_EN = 1'b1;
`else
  localparam bit TIMING_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [2:0]  ns, we;
  logic [2:0]  phase;
  logic        phase_valid, err_illegal, err_conflict, err_seq, err_timing;
  logic [15:0] cycles_done;

  int vectors;
  int miscompares;

  // Reference model state
  int m_phase, m_dwell, m_rot;
  bit m_checked, m_ill, m_con, m_seq, m_tim;

  tlight_monitor dut (
    .clock        (clock),
    .reset        (reset),
    .ns           (ns),
    .we           (we),
    .phase        (phase),
    .phase_valid  (phase_valid),
    .err_illegal  (err_illegal),
    .err_conflict (err_conflict),
    .err_seq      (err_seq),
    .err_timing   (err_timing),
    .cycles_done  (cycles_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Lamp pair shown during each phase of the rotation 1..6
  function automatic logic [5:0] pair_of(int p);
    case (p)
      1, 3:    return P_RY;
      2:       return P_RG;
      4, 6:    return P_YR;
      5:       return P_GR;
      default: return P_RR;
    endcase
  endfunction

  function automatic int req_of(int p);
    case (p)
      1, 4:    return 3;
      2, 5:    return 15;
      default: return 1;
    endcase
  endfunction

  function automatic bit legal_code(logic [2:0] b);
    return (b == RED) || (b == YEL) || (b == GRN);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_dwell = 0; m_rot = 0;
    m_checked = 0; m_ill = 0; m_con = 0; m_seq = 0; m_tim = 0;
  endtask

  task automatic model_step(input logic [2:0] n, input logic [2:0] w);
    logic [5:0] p;
    int nxt, succ;
    bit in_phase;
    p = {n, w};
    succ = (m_phase == 6) ? 1 : m_phase + 1;
    in_phase = (m_phase >= 1) && (m_phase <= 6);
    if (!legal_code(n) || !legal_code(w)) begin
      m_ill = 1; nxt = 7;
    end else if ((n != RED) && (w != RED)) begin
      m_con = 1; nxt = 7;
    end else if (m_phase == 0) begin
      nxt = (p == P_RR) ? 0 : (p == P_RY) ? 1 : 7;
    end else if (m_phase == 7) begin
      nxt = (p == P_RG) ? 2 : (p == P_GR) ? 5 : (p == P_RR) ? 0 : 7;
    end else if (p == pair_of(m_phase)) begin
      nxt = m_phase;
    end else if (p == pair_of(succ)) begin
      nxt = succ;
    end else begin
      m_seq = 1; nxt = 7;
    end
    if (nxt != m_phase) begin
      if (TIMING_EN && in_phase && m_checked && (m_dwell != req_of(m_phase))) m_tim = 1;
      if ((m_phase == 6) && (nxt == 1) && (m_rot < 65535)) m_rot++;
      m_checked = in_phase;
      m_dwell = 1;
    end else if (m_dwell < 255) begin
      m_dwell++;
    end
    m_phase = nxt;
  endtask

  // One clock: drive at negedge, update model at posedge, leave time 1 after the edge for sampling
  task automatic drive(input logic [5:0] p, input logic r);
    @(negedge clock);
    ns = p[5:3]; we = p[2:0]; reset = r;
    @(posedge clock);
    if (r) model_reset(); else model_step(p[5:3], p[2:0]);
    #1;
  endtask

  task automatic run(input logic [5:0] p, input int n);
    for (int i = 0; i < n; i++) drive(p, 1'b0);
  endtask

  task automatic test_reset();
    drive(6'($urandom), 1'b1);
    drive(6'($urandom), 1'b1);
    vectors++; if (phase !== 3'd0) begin miscompares++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    vectors++; if (phase_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", phase_valid); end
    vectors++; if ({err_illegal, err_conflict, err_seq, err_timing} !== 4'b0) begin miscompares++; $display("FAIL reset_errs: got %b expected 0000", {err_illegal, err_conflict, err_seq, err_timing}); end
    vectors++; if (cycles_done !== 16'd0) begin miscompares++; $display("FAIL reset_cycles: got %0d expected 0", cycles_done); end
  endtask

  task automatic test_rotation();
    run(P_RR, 2);
    vectors++; if (phase !== 3'd0) begin miscompares++; $display("FAIL rot_idle: got %0d expected 0", phase); end
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 6; k++) begin
        run(pair_of(k), req_of(k));
        vectors++; if (phase !== 3'(k) || phase_valid !== 1'b1) begin miscompares++; $display("FAIL rot_phase r%0d: got %0d/%b expected %0d/1", r, phase, phase_valid, k); end
      end
    end
    vectors++; if ({err_illegal, err_conflict, err_seq, err_timing} !== 4'b0) begin miscompares++; $display("FAIL rot_errs: got %b expected 0000", {err_illegal, err_conflict, err_seq, err_timing}); end
    vectors++; if (cycles_done !== 16'd2) begin miscompares++; $display("FAIL rot_cycles2: got %0d expected 2", cycles_done); end
    drive(P_RY, 1'b0);
    vectors++; if (cycles_done !== 16'd3 || phase !== 3'd1) begin miscompares++; $display("FAIL rot_cycles3: got %0d phase %0d expected 3 phase 1", cycles_done, phase); end
  endtask

  task automatic test_conflict();
    run(P_RY, 2);
    run(P_RG, 5);
    vectors++; if (phase !== 3'd2) begin miscompares++; $display("FAIL conf_pre: got %0d expected 2", phase); end
    drive(P_GG, 1'b0);
    vectors++; if (err_conflict !== 1'b1 || phase !== 3'd7 || phase_valid !== 1'b0) begin miscompares++; $display("FAIL conf_hit: got c=%b ph=%0d v=%b expected 1 7 0", err_conflict, phase, phase_valid); end
    vectors++; if (err_illegal !== 1'b0 || err_timing !== m_tim) begin miscompares++; $display("FAIL conf_side: got ill=%b tim=%b expected 0 %b", err_illegal, err_timing, m_tim); end
    drive(P_GR, 1'b0);
    vectors++; if (phase !== 3'd5 || err_conflict !== 1'b1 || phase_valid !== 1'b1) begin miscompares++; $display("FAIL conf_resync: got ph=%0d c=%b v=%b expected 5 1 1", phase, err_conflict, phase_valid); end
  endtask

  task automatic test_illegal();
    drive(P_RR, 1'b1);
    drive(P_RR, 1'b0);
    drive({GRN, 3'b110}, 1'b0);
    vectors++; if (err_illegal !== 1'b1 || phase !== 3'd7) begin miscompares++; $display("FAIL ill_hit: got ill=%b ph=%0d expected 1 7", err_illegal, phase); end
    vectors++; if (err_conflict !== 1'b0) begin miscompares++; $display("FAIL ill_prio: got conflict=%b expected 0", err_conflict); end
  endtask

  task automatic test_seq();
    drive(P_RR, 1'b1);
    drive(P_RR, 1'b0);
    drive(P_RY, 1'b0);
    vectors++; if (phase !== 3'd1) begin miscompares++; $display("FAIL seq_pre: got %0d expected 1", phase); end
    drive(P_GR, 1'b0);
    vectors++; if (err_seq !== 1'b1 || phase !== 3'd7) begin miscompares++; $display("FAIL seq_hit: got seq=%b ph=%0d expected 1 7", err_seq, phase); end
    vectors++; if (err_illegal !== 1'b0 || err_conflict !== 1'b0) begin miscompares++; $display("FAIL seq_side: got ill=%b c=%b expected 0 0", err_illegal, err_conflict); end
  endtask

  task automatic test_timing();
    drive(P_RR, 1'b1);
    drive(P_RR, 1'b0);
    for (int k = 1; k <= 6; k++) run(pair_of(k), req_of(k));
    run(P_RY, 3);
    run(P_RG, 14);
    vectors++; if (err_timing !== 1'b0 || phase !== 3'd2) begin miscompares++; $display("FAIL tim_clean: got tim=%b ph=%0d expected 0 2", err_timing, phase); end
    drive(P_RY, 1'b0);
    vectors++; if (err_timing !== TIMING_EN || phase !== 3'd3) begin miscompares++; $display("FAIL tim_short_go: got tim=%b ph=%0d expected %b 3", err_timing, phase, TIMING_EN); end
    vectors++; if (err_seq !== 1'b0) begin miscompares++; $display("FAIL tim_seq: got %b expected 0", err_seq); end
  endtask

  task automatic test_reset_mid();
    drive(P_RR, 1'b1);
    drive(P_RR, 1'b0);
    drive(P_RY, 1'b0);
    run(P_GR, 2);
    vectors++; if (phase !== 3'd5 || err_seq !== 1'b1) begin miscompares++; $display("FAIL rmid_pre: got ph=%0d seq=%b expected 5 1", phase, err_seq); end
    drive(P_GR, 1'b1);
    vectors++; if ({phase, phase_valid, err_illegal, err_conflict, err_seq, err_timing} !== 8'd0 || cycles_done !== 16'd0) begin miscompares++; $display("FAIL rmid_reset: got ph=%0d v=%b errs=%b cyc=%0d expected all 0", phase, phase_valid, {err_illegal, err_conflict, err_seq, err_timing}, cycles_done); end
    drive(P_RR, 1'b0);
    run(P_RY, 2);
    drive(P_RG, 1'b0);
    vectors++; if (phase !== 3'd2 || err_timing !== 1'b0) begin miscompares++; $display("FAIL rmid_first: got ph=%0d tim=%b expected 2 0", phase, err_timing); end
  endtask

  task automatic test_random();
    int gi, len, sel;
    logic [5:0] p;
    logic r;
    gi = 1;
    drive(P_RR, 1'b1);
    for (int s = 0; s < 400; s++) begin
      sel = int'($urandom_range(0, 99));
      r = 1'b0;
      if (sel < 2) begin
        p = 6'($urandom); len = 1; r = 1'b1; gi = 1;
      end else if (sel < 8) begin
        p = 6'($urandom); len = 1;
      end else if (sel < 14) begin
        case ($urandom_range(0, 4))
          0: p = P_RR; 1: p = P_RY; 2: p = P_RG; 3: p = P_YR; default: p = P_GR;
        endcase
        len = int'($urandom_range(1, 4));
      end else begin
        p = pair_of(gi);
        len = req_of(gi);
        if (sel < 30) len = len + int'($urandom_range(0, 2)) - 1;
        if (sel >= 98) len = 260;
        if (len < 1) len = 1;
        gi = (gi == 6) ? 1 : gi + 1;
      end
      for (int i = 0; i < len; i++) begin
        drive(p, r);
        vectors++; if (phase !== 3'(m_phase)) begin miscompares++; $display("FAIL rand_phase s%0d: got %0d expected %0d", s, phase, m_phase); end
        vectors++; if (phase_valid !== ((m_phase >= 1) && (m_phase <= 6))) begin miscompares++; $display("FAIL rand_valid s%0d: got %b for phase %0d", s, phase_valid, m_phase); end
        vectors++; if (err_illegal !== m_ill) begin miscompares++; $display("FAIL rand_illegal s%0d: got %b expected %b", s, err_illegal, m_ill); end
        vectors++; if (err_conflict !== m_con) begin miscompares++; $display("FAIL rand_conflict s%0d: got %b expected %b", s, err_conflict, m_con); end
        vectors++; if (err_seq !== m_seq) begin miscompares++; $display("FAIL rand_seq s%0d: got %b expected %b", s, err_seq, m_seq); end
        vectors++; if (err_timing !== m_tim) begin miscompares++; $display("FAIL rand_timing s%0d: got %b expected %b", s, err_timing, m_tim); end
        vectors++; if (cycles_done !== 16'(m_rot)) begin miscompares++; $display("FAIL rand_cycles s%0d: got %0d expected %0d", s, cycles_done, m_rot); end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    ns = RED;
    we = RED;
    model_reset();
    test_reset();
    test_rotation();
    test_conflict();
    test_illegal();
    test_seq();
    test_timing();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
